// File: rtl/uart_transmitter.sv
// UART transmit stage: 1 start, 8 data (LSB first), even parity, 1 stop.
// Bit timing comes from a free-running Baud_controller tick at 16x baud.

module Baud_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       sample_ENABLE
);
  logic [14:0] div_max;
  logic [14:0] cnt;

  // Terminal counts for a 100 MHz clock, 16 ticks per bit: 300 .. 115200 baud
  always_comb begin
    div_max = 15'd53;
    case (baud_select)
      3'd0: div_max = 15'd20832;
      3'd1: div_max = 15'd5207;
      3'd2: div_max = 15'd1301;
      3'd3: div_max = 15'd650;
      3'd4: div_max = 15'd325;
      3'd5: div_max = 15'd162;
      3'd6: div_max = 15'd108;
      3'd7: div_max = 15'd53;
      default: div_max = 15'd53;
    endcase
  end

  // >= lets a mid-count switch to a faster rate wrap cleanly
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 15'd0;
    end else if (cnt >= div_max) begin
      cnt <= 15'd0;
    end else begin
      cnt <= cnt + 15'd1;
    end
  end

  assign sample_ENABLE = (cnt == div_max);
endmodule

module uart_transmitter #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Tx_DATA,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  output logic       Tx_D,
  output logic       Tx_BUSY,
  output logic       Tx_DONE,
  output logic [2:0] state_dbg
);
  localparam int TW = $clog2(OVERSAMPLE);

  localparam logic [2:0] T_OFF    = 3'd0;
  localparam logic [2:0] T_IDLE   = 3'd1;
  localparam logic [2:0] T_START  = 3'd2;
  localparam logic [2:0] T_DATA   = 3'd3;
  localparam logic [2:0] T_PARITY = 3'd4;
  localparam logic [2:0] T_STOP   = 3'd5;

  logic          sample_enable;
  logic [2:0]    state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          parity_bit;
  logic          in_frame;
  logic          bit_end;

  Baud_controller u_baud (
    .clk           (clk),
    .reset         (reset),
    .baud_select   (baud_select),
    .sample_ENABLE (sample_enable)
  );

  assign in_frame  = (state == T_START) || (state == T_DATA) ||
                     (state == T_PARITY) || (state == T_STOP);
  assign bit_end   = in_frame && sample_enable && (tick_cnt == TW'(OVERSAMPLE - 1));
  assign state_dbg = state;

  // Tx_D is registered: each branch loads the level of the bit being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= T_OFF;
      tick_cnt   <= '0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'h00;
      parity_bit <= 1'b0;
      Tx_D       <= 1'b1;
      Tx_BUSY    <= 1'b0;
      Tx_DONE    <= 1'b0;
    end else begin
      Tx_DONE <= 1'b0;
      if (in_frame && sample_enable) begin
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
      end
      case (state)
        T_OFF: begin
          Tx_D    <= 1'b1;
          Tx_BUSY <= 1'b0;
          if (Tx_EN) state <= T_IDLE;
        end
        T_IDLE: begin
          Tx_D    <= 1'b1;
          Tx_BUSY <= 1'b0;
          if (!Tx_EN) begin
            state <= T_OFF;
          end else if (Tx_WR) begin
            shift_reg  <= Tx_DATA;
            parity_bit <= ^Tx_DATA;
            tick_cnt   <= '0;
            bit_idx    <= 3'd0;
            Tx_D       <= 1'b0;
            Tx_BUSY    <= 1'b1;
            state      <= T_START;
          end
        end
        T_START: begin
          if (bit_end) begin
            bit_idx <= 3'd0;
            Tx_D    <= shift_reg[0];
            state   <= T_DATA;
          end
        end
        T_DATA: begin
          if (bit_end) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              Tx_D  <= parity_bit;
              state <= T_PARITY;
            end else begin
              Tx_D <= shift_reg[1];
            end
          end
        end
        T_PARITY: begin
          if (bit_end) begin
            Tx_D  <= 1'b1;
            state <= T_STOP;
          end
        end
        T_STOP: begin
          Tx_D <= 1'b1;
          if (bit_end) begin
            Tx_DONE <= 1'b1;
            Tx_BUSY <= 1'b0;
            state   <= Tx_EN ? T_IDLE : T_OFF;
          end
        end
        default: begin
          Tx_D    <= 1'b1;
          Tx_BUSY <= 1'b0;
          state   <= T_OFF;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: cycle-level frame model, mid-bit line decoder
// and a scoreboard of hand-computed frames.

module tb_uart_transmitter;
  localparam int OS      = 16;
  localparam int DIV     = 54;  // clocks per sample tick at baud_select 3'b111
  localparam int BIT_CYC = OS * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Tx_DATA;
  logic [2:0] baud_select;
  logic       Tx_EN;
  logic       Tx_WR;
  logic       Tx_D;
  logic       Tx_BUSY;
  logic       Tx_DONE;
  logic [2:0] state_dbg;

  uart_transmitter #(.OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .reset       (reset),
    .Tx_DATA     (Tx_DATA),
    .baud_select (baud_select),
    .Tx_EN       (Tx_EN),
    .Tx_WR       (Tx_WR),
    .Tx_D        (Tx_D),
    .Tx_BUSY     (Tx_BUSY),
    .Tx_DONE     (Tx_DONE),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic even_par(input logic [7:0] d);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) if (d[i]) c++;
    return c[0];
  endfunction

  // Frame model: counts sample ticks since acceptance; bit k spans ticks [16k, 16k+16)
  bit          m_valid = 1'b0;
  bit          m_on, m_busy, m_level, m_done, m_samp;
  int          m_edges, m_pulses;
  logic [10:0] m_frame;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_on    = 1'b0;
      m_busy  = 1'b0;
      m_level = 1'b1;
      m_done  = 1'b0;
      m_edges = 0;
    end else begin
      m_samp = ((m_edges % DIV) == DIV - 1);
      m_edges++;
      m_done = 1'b0;
      if (m_busy) begin
        if (m_samp) begin
          m_pulses++;
          if (m_pulses == 11 * OS) begin
            m_busy  = 1'b0;
            m_done  = 1'b1;
            m_level = 1'b1;
            m_on    = Tx_EN;
          end else begin
            m_level = m_frame[m_pulses / OS];
          end
        end
      end else if (!m_on) begin
        m_level = 1'b1;
        if (Tx_EN) m_on = 1'b1;
      end else if (!Tx_EN) begin
        m_on = 1'b0;
      end else if (Tx_WR) begin
        m_frame  = {1'b1, even_par(Tx_DATA), Tx_DATA, 1'b0};
        m_busy   = 1'b1;
        m_pulses = 0;
        m_level  = 1'b0;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (m_valid) begin
      n_cmp++;
      if ({Tx_D, Tx_BUSY, Tx_DONE} !== {m_level, m_busy, m_done}) begin
        n_bad++;
        $display("FAIL cycle: got D/BUSY/DONE=%b%b%b expected %b%b%b at %0t",
                 Tx_D, Tx_BUSY, Tx_DONE, m_level, m_busy, m_done, $time);
      end
    end
    if (Tx_DONE === 1'b1) n_done++;
  end

  // Line decoder: samples each bit mid-way, timed from the start-bit fall
  bit          dec_active = 1'b0;
  int          dec_cnt, dec_k;
  logic [10:0] dec_vec;
  logic        prev_txd;
  logic [10:0] got_q[$];
  logic [10:0] exp_q[$];

  always @(negedge clk) begin
    if (reset) begin
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (prev_txd === 1'b1 && Tx_D === 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt >= BIT_CYC / 2 && ((dec_cnt - BIT_CYC / 2) % BIT_CYC) == 0) begin
        dec_k          = (dec_cnt - BIT_CYC / 2) / BIT_CYC;
        dec_vec[dec_k] = Tx_D;
        if (dec_k == 10) begin
          got_q.push_back(dec_vec);
          dec_active = 1'b0;
        end
      end
    end
    prev_txd = Tx_D;
  end

  // driver tasks
  task automatic write_byte(input logic [7:0] d);
    Tx_DATA = d;
    Tx_WR   = 1'b1;
    @(negedge clk);
    Tx_WR   = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (Tx_DONE === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: Tx_DONE not seen within %0d cycles", name, bound);
    end
  endtask

  initial begin
    reset       = 1'b1;
    Tx_EN       = 1'b0;
    Tx_WR       = 1'b0;
    Tx_DATA     = 8'h00;
    baud_select = 3'b111;
    exp_q.push_back({1'b1, 1'b0, 8'hA5, 1'b0});
    exp_q.push_back({1'b1, 1'b1, 8'h07, 1'b0});
    exp_q.push_back({1'b1, 1'b0, 8'h00, 1'b0});
    exp_q.push_back({1'b1, 1'b0, 8'h5A, 1'b0});
    repeat (3) @(negedge clk);
    check("reset_txd", Tx_D, 1);
    check("reset_busy", Tx_BUSY, 0);
    check("reset_done", Tx_DONE, 0);
    reset = 1'b0;

    // disabled: write is ignored
    repeat (3) @(negedge clk);
    write_byte(8'h3C);
    repeat (20) @(negedge clk);
    check("off_txd", Tx_D, 1);
    check("off_busy", Tx_BUSY, 0);
    check("off_done_cnt", n_done, 0);

    // 0xA5 frame; a 0xFF write during data bit 3 must be ignored
    Tx_EN = 1'b1;
    repeat (2) @(negedge clk);
    write_byte(8'hA5);
    check("accept_txd", Tx_D, 0);
    check("accept_busy", Tx_BUSY, 1);
    Tx_DATA = 8'h00;
    repeat (BIT_CYC / 2 + 4 * BIT_CYC - 1) @(negedge clk);
    write_byte(8'hFF);
    check("busy_mid_frame", Tx_BUSY, 1);
    wait_done("a5_done", 12 * BIT_CYC);
    check("done_busy_low", Tx_BUSY, 0);
    repeat (2000) @(negedge clk);
    check("no_second_frame", Tx_BUSY, 0);
    check("a5_frame_count", got_q.size(), 1);

    // 0x07 then 0x00 back-to-back
    write_byte(8'h07);
    wait_done("07_done", 12 * BIT_CYC);
    write_byte(8'h00);
    check("b2b_start_txd", Tx_D, 0);
    check("b2b_start_busy", Tx_BUSY, 1);
    wait_done("00_done", 12 * BIT_CYC);
    @(negedge clk);

    // reset during data bit 4 aborts; then a clean 0x5A frame
    write_byte(8'h3C);
    repeat (BIT_CYC / 2 + 5 * BIT_CYC) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_txd", Tx_D, 1);
    check("abort_busy", Tx_BUSY, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    write_byte(8'h5A);
    wait_done("5a_done", 12 * BIT_CYC);
    repeat (100) @(negedge clk);

    // scoreboard
    check("done_count", n_done, 4);
    check("frame_count", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check("frame_bits", got_q.pop_front(), exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serial UART transmit stage; drives the serial line consumed by uart_reciever.
- Accepts a parallel byte through a one-cycle write strobe.
- Emits one frame: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1).
- Bit timing comes from an instantiated Baud_controller, which pulses sample_ENABLE at 16x the baud rate chosen by baud_select. Each serial bit lasts OVERSAMPLE such pulses.

Parameters:
OVERSAMPLE, 16, sample_ENABLE pulses per serial bit; must match the receiver's oversampling.

Ports:
clk  input  1  system clock; single clock domain, all logic on posedge.
reset  input  1  synchronous, active-high reset.
Tx_DATA  input  8  byte to send; sampled only on the accepted Tx_WR cycle.
baud_select  input  3  baud rate code, passed straight to Baud_controller.
Tx_EN  input  1  transmitter enable.
Tx_WR  input  1  one-cycle write strobe.
Tx_D  output  1  serial line; registered; idles high.
Tx_BUSY  output  1  high from byte acceptance until stop-bit end.
Tx_DONE  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: Tx_D=1, Tx_BUSY=0, Tx_DONE=0, state T_OFF, tick counter 0, bit index 0, shift register 0x00.
- Reset mid-frame aborts the frame: Tx_D=1 on the next edge, no Tx_DONE.

States: T_OFF, T_IDLE, T_START, T_DATA, T_PARITY, T_STOP.
- T_OFF: Tx_D=1, Tx_BUSY=0. Tx_WR is ignored. Tx_EN=1 moves to T_IDLE on the next edge.
- T_IDLE: Tx_D=1, Tx_BUSY=0.
  - Tx_EN=0 moves to T_OFF.
  - Otherwise, Tx_WR=1 accepts the byte on that edge: latch Tx_DATA into the shift register, latch parity=^Tx_DATA, clear the tick counter and bit index, and go to T_START.
  - Tx_WR and Tx_EN=0 in the same cycle: Tx_EN wins; byte not accepted.
- Latency: Tx_WR high at edge N gives Tx_D=0 and Tx_BUSY=1 after edge N. There is no combinational path from Tx_WR to Tx_D.
- Tick counter: a log2(OVERSAMPLE)-bit counter.
  - It increments only on cycles where sample_ENABLE=1.
  - A bit ends on the cycle where sample_ENABLE=1 and counter==OVERSAMPLE-1; the counter then wraps to 0.
  - Baud_controller runs freely, so the start bit may be up to one tick period shorter than nominal. Every following bit is exactly OVERSAMPLE tick periods long.
- T_START: Tx_D=0. At bit end, go to T_DATA with bit index 0.
- T_DATA: Tx_D=shift register bit 0.
  - At bit end, shift right by one and increment the bit index.
  - When the index reaches 7 at bit end, go to T_PARITY.
- T_PARITY: Tx_D=latched parity (XOR of the 8 data bits, i.e. even parity). At bit end, go to T_STOP.
- T_STOP: Tx_D=1.
  - At bit end, Tx_DONE=1 for exactly one cycle and Tx_BUSY falls on the same edge.
  - Next state is T_IDLE if Tx_EN=1, else T_OFF.
- Frame length: 11 bits = 11*OVERSAMPLE sample_ENABLE pulses, ±1 on the start bit.
- Tx_WR while Tx_BUSY=1: ignored. No buffering; Tx_DATA changes during a frame do not affect it.
- Tx_EN dropped mid-frame: the current frame completes normally, then the block enters T_OFF.
- Back-to-back frames: Tx_WR on the cycle after Tx_DONE is accepted. The minimum inter-frame gap is 1 clk at Tx_D=1.
- baud_select change mid-frame: permitted; the new rate applies from the next sample_ENABLE pulse. Not a supported use case.
- Illegal or unreachable state encodings recover to T_OFF with Tx_D=1.

Test Plan:
1. Reset with Tx_EN=0, then pulse Tx_WR with Tx_DATA=0x3C -> Tx_D stays 1, Tx_BUSY stays 0, no Tx_DONE.
2. Tx_EN=1, baud_select=3'b111, Tx_WR with Tx_DATA=0xA5 -> Tx_D sequence 0,1,0,1,0,0,1,0,1,0(parity),1(stop). Each bit after the start bit lasts 16 sample_ENABLE pulses. Tx_BUSY=1 throughout; a single Tx_DONE pulse at the end.
3. Tx_WR with Tx_DATA=0x07 -> parity bit 1. Then Tx_WR with Tx_DATA=0x00 on the cycle after Tx_DONE -> second frame starts 1 clk later with parity 0.
4. During the 0xA5 frame, pulse Tx_WR with Tx_DATA=0xFF at data bit 3 -> ignored; the frame still carries 0xA5 and no second frame follows.
5. Assert reset during data bit 4 -> Tx_D=1 and Tx_BUSY=0 on the next edge, no Tx_DONE. Tx_EN=1 then Tx_WR 0x5A afterwards -> a clean full frame.
6. Loopback Tx_D into uart_reciever Rx_D, same baud_select=3'b011, with Rx_EN=1 and Tx_EN=1. Send 0xA5, then 0x3C -> Rx_VALID=1 with Rx_DATA=0xA5, then Rx_DATA=0x3C.
